id_ex_stage: RTL
================

Name: id_ex_stage

Overview:
- ID/EX pipeline register for the 4-bit-opcode pipelined CPU.
- Captures the EX (5-bit) and MEM (7-bit) control bundles from the decode control unit, together with register indices and operand data, and presents them to the EX stage.
- Contains load-use hazard detection. On a hazard it inserts a programmable number of bubbles and stalls upstream.
- Supports downstream stall (hold) and branch/jump flush (squash).

Parameters:
- DATA_W, 32, operand data width.
- REG_W, 6, register index width (64-entry register file).
- LOAD_BUBBLES, 1, bubbles inserted per load-use hazard; legal range 1..7.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous, active-low reset.
- InValid  in  1  ID holds a valid instruction.
- InEX  in  5  {ALUOP[2:0], MemRead, MemWrite} from control.
- InMEM  in  7  {RegWrite, MemToReg, PCtoReg, Jump, JumpMem, BranchN, BranchZ}.
- InRs, InRt  in  REG_W  source register indices.
- InRd  in  REG_W  destination register index.
- InRsData, InRtData  in  DATA_W  register-file read data.
- Flush  in  1  taken branch/jump resolved downstream; squash the instruction in ID.
- ExStall  in  1  EX cannot accept; hold the stage.
- IDStall  out  1  combinational; upstream (PC, IF/ID) must hold.
- OutValid  out  1  stage holds a valid instruction.
- OutEX  out  5  registered EX bundle.
- OutMEM  out  7  registered MEM bundle.
- OutRs, OutRt, OutRd  out  REG_W  registered indices.
- OutRsData, OutRtData  out  DATA_W  registered operands.

Behaviour:
- Reset (rst_n low at the edge):
  - All Out* go to 0.
  - State goes to RUN and the bubble counter goes to 0.
  - IDStall is forced to 0 while rst_n is low.
- A bubble means OutValid=0, OutEX=0 and OutMEM=0. Indices and data are also cleared to 0.
- Hazard detect (combinational, sub-module) is asserted when all of the following hold:
  - state is RUN,
  - InValid and OutValid are 1,
  - OutEX[1] (MemRead) and OutMEM[6] (RegWrite) are 1,
  - InRs==OutRd or InRt==OutRd.
- No register-0 exemption: all register indices are compared.
- Edge priority, highest first:
  1. Reset.
  2. Flush: load a bubble, state to RUN, counter to 0.
  3. ExStall: hold all registers, state and counter unchanged.
  4. Hazard detect: load a bubble; counter = LOAD_BUBBLES-1; state = HAZARD if that value is nonzero, else RUN.
  5. State HAZARD: load a bubble and decrement the counter; go to RUN when the counter reaches 0.
  6. Otherwise, capture In*, with OutValid=InValid. If InValid=0, capture a bubble instead.
- IDStall = rst_n & ~Flush & (ExStall | hazard_detect | state==HAZARD).
- Latency: 1 cycle from In* to Out* when there is no stall or hazard.
- A load that is followed by a dependent instruction yields exactly LOAD_BUBBLES bubble cycles before the dependent instruction appears on Out*.
- After the bubbles, OutValid=0, so the same load cannot re-trigger detection.
- ExStall asserted during HAZARD freezes the counter. Bubbles resume when ExStall drops.
- Simultaneous Flush and ExStall: Flush wins, and the stage is bubbled.
- Reset asserted mid-HAZARD: the reset state applies at the next edge.

Decomposition:
- Shared package (cpu_pkg):
  - EX_W=5 and MEM_W=7.
  - Bit indices: EX_MEMREAD=1, EX_MEMWRITE=0, EX_ALUOP=[4:2], MEM_REGWRITE=6 … MEM_BRANCHZ=0.
  - Stage state enum {RUN, HAZARD}.
- One sub-module: load_use_detect, the purely combinational comparator producing hazard_detect.
- The top-level block holds the registers, state and counter.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with InValid=1 and InEX=5'b10000 -> all Out*=0 and IDStall=0. The first post-reset edge captures normally.
- Pass-through:
  - Stimulus: InEX=5'b10000, InMEM=7'b1000000, InRd=5, InRsData=0x11, InRtData=0x22.
  - Response: the next cycle shows the same values on Out*, OutValid=1 and IDStall=0.
- Load-use with LOAD_BUBBLES=1:
  - Load (InEX=5'b11110, InMEM=7'b1100000, InRd=7) is captured at edge n.
  - Cycle n+1: InRs=7 with InValid=1 -> IDStall=1.
  - Edge n+1: bubble captured (OutEX=0, OutMEM=0).
  - Cycle n+2: IDStall=0. The dependent instruction is on Out* after edge n+2.
- Same hazard with LOAD_BUBBLES=3 -> IDStall high for 3 cycles, 3 consecutive bubbles, then the dependent instruction.
- ExStall held 3 cycles during pass-through -> Out* unchanged and IDStall=1 throughout.
  - Flush asserted in the second stall cycle -> bubble at that edge, IDStall=0 in that cycle.
- Flush during HAZARD (LOAD_BUBBLES=3, after the first bubble) -> counter cleared, state RUN, bubble loaded. The next valid In* is captured at the following edge.

Source files
------------

// File: rtl/cpu_pkg.sv
// ============================================================================
// Module : cpu_pkg
// Brief  : Shared control-bundle layout and stage-state type for the 4-bit-opcode CPU.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package cpu_pkg;

    localparam int EX_W  = 5;
    localparam int MEM_W = 7;

    // EX bundle bit positions: {ALUOP[2:0], MemRead, MemWrite}
    localparam int EX_MEMWRITE  = 0;
    localparam int EX_MEMREAD   = 1;
    localparam int EX_ALUOP_LSB = 2;
    localparam int EX_ALUOP_MSB = 4;

    // MEM bundle bit positions: {RegWrite, MemToReg, PCtoReg, Jump, JumpMem, BranchN, BranchZ}
    localparam int MEM_BRANCHZ  = 0;
    localparam int MEM_BRANCHN  = 1;
    localparam int MEM_JUMPMEM  = 2;
    localparam int MEM_JUMP     = 3;
    localparam int MEM_PCTOREG  = 4;
    localparam int MEM_MEMTOREG = 5;
    localparam int MEM_REGWRITE = 6;

    // Bubble counter width covers LOAD_BUBBLES-1 for LOAD_BUBBLES up to 7
    localparam int CNT_W = 3;

    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_HAZARD = 1'b1
    } stage_state_e;

endpackage

`default_nettype wire

// File: rtl/load_use_detect.sv
// ============================================================================
// Module : load_use_detect
// Brief  : Combinational load-use comparator between the ID instruction and the load in ID/EX.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module load_use_detect
    import cpu_pkg::*;
#(
    parameter int REG_W = 6
) (
    input  logic         state,
    input  logic         in_valid,
    input  logic         out_valid,
    input  logic         out_memread,
    input  logic         out_regwrite,
    input  logic [REG_W-1:0] in_rs,
    input  logic [REG_W-1:0] in_rt,
    input  logic [REG_W-1:0] out_rd,
    output logic         hazard_detect
);

    logic w_run;
    logic w_is_load;
    logic w_dep;

    assign w_run         = (state == ST_RUN);
    assign w_is_load     = out_valid & out_memread & out_regwrite;
    // Register 0 is compared like any other index
    assign w_dep         = (in_rs == out_rd) | (in_rt == out_rd);
    assign hazard_detect = w_run & in_valid & w_is_load & w_dep;

endmodule

`default_nettype wire

// File: rtl/id_ex_stage.sv
// ============================================================================
// Module : id_ex_stage
// Brief  : ID/EX pipeline register with load-use bubble insertion, hold and squash.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module id_ex_stage
    import cpu_pkg::*;
#(
    parameter int DATA_W       = 32,
    parameter int REG_W        = 6,
    parameter int LOAD_BUBBLES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              InValid,
    input  logic [EX_W-1:0]   InEX,
    input  logic [MEM_W-1:0]  InMEM,
    input  logic [REG_W-1:0]  InRs,
    input  logic [REG_W-1:0]  InRt,
    input  logic [REG_W-1:0]  InRd,
    input  logic [DATA_W-1:0] InRsData,
    input  logic [DATA_W-1:0] InRtData,
    input  logic              Flush,
    input  logic              ExStall,
    output logic              IDStall,
    output logic              OutValid,
    output logic [EX_W-1:0]   OutEX,
    output logic [MEM_W-1:0]  OutMEM,
    output logic [REG_W-1:0]  OutRs,
    output logic [REG_W-1:0]  OutRt,
    output logic [REG_W-1:0]  OutRd,
    output logic [DATA_W-1:0] OutRsData,
    output logic [DATA_W-1:0] OutRtData
);

    localparam logic [CNT_W-1:0] c_bubbles_m1 = CNT_W'(LOAD_BUBBLES - 1);

    stage_state_e        r_state;
    stage_state_e        w_state_next;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    w_cnt_next;
    logic [CNT_W-1:0]    w_cnt_dec;

    logic                r_valid;
    logic [EX_W-1:0]     r_ex;
    logic [MEM_W-1:0]    r_mem;
    logic [REG_W-1:0]    r_rs;
    logic [REG_W-1:0]    r_rt;
    logic [REG_W-1:0]    r_rd;
    logic [DATA_W-1:0]   r_rsd;
    logic [DATA_W-1:0]   r_rtd;

    logic                w_valid_next;
    logic [EX_W-1:0]     w_ex_next;
    logic [MEM_W-1:0]    w_mem_next;
    logic [REG_W-1:0]    w_rs_next;
    logic [REG_W-1:0]    w_rt_next;
    logic [REG_W-1:0]    w_rd_next;
    logic [DATA_W-1:0]   w_rsd_next;
    logic [DATA_W-1:0]   w_rtd_next;

    logic                w_hazard;
    logic                w_bubble;
    logic                w_capture;

    load_use_detect #(
        .REG_W (REG_W)
    ) u_load_use_detect (
        .state         (r_state),
        .in_valid      (InValid),
        .out_valid     (r_valid),
        .out_memread   (r_ex[EX_MEMREAD]),
        .out_regwrite  (r_mem[MEM_REGWRITE]),
        .in_rs         (InRs),
        .in_rt         (InRt),
        .out_rd        (r_rd),
        .hazard_detect (w_hazard)
    );

    assign w_cnt_dec = r_cnt - CNT_W'(1);

    // Control priority: flush, then hold, then hazard entry, then bubble drain, then capture
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_bubble     = 1'b0;
        w_capture    = 1'b0;
        if (Flush) begin
            w_bubble     = 1'b1;
            w_state_next = ST_RUN;
            w_cnt_next   = '0;
        end else if (ExStall) begin
            w_bubble     = 1'b0;
        end else if (w_hazard) begin
            w_bubble     = 1'b1;
            w_cnt_next   = c_bubbles_m1;
            w_state_next = (c_bubbles_m1 != '0) ? ST_HAZARD : ST_RUN;
        end else if (r_state == ST_HAZARD) begin
            w_bubble     = 1'b1;
            w_cnt_next   = w_cnt_dec;
            w_state_next = (w_cnt_dec == '0) ? ST_RUN : ST_HAZARD;
        end else if (InValid) begin
            w_capture    = 1'b1;
        end else begin
            w_bubble     = 1'b1;
        end
    end

    always_comb begin
        w_valid_next = r_valid;
        w_ex_next    = r_ex;
        w_mem_next   = r_mem;
        w_rs_next    = r_rs;
        w_rt_next    = r_rt;
        w_rd_next    = r_rd;
        w_rsd_next   = r_rsd;
        w_rtd_next   = r_rtd;
        if (w_bubble) begin
            w_valid_next = 1'b0;
            w_ex_next    = '0;
            w_mem_next   = '0;
            w_rs_next    = '0;
            w_rt_next    = '0;
            w_rd_next    = '0;
            w_rsd_next   = '0;
            w_rtd_next   = '0;
        end else if (w_capture) begin
            w_valid_next = 1'b1;
            w_ex_next    = InEX;
            w_mem_next   = InMEM;
            w_rs_next    = InRs;
            w_rt_next    = InRt;
            w_rd_next    = InRd;
            w_rsd_next   = InRsData;
            w_rtd_next   = InRtData;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_RUN;
            r_cnt   <= '0;
            r_valid <= 1'b0;
            r_ex    <= '0;
            r_mem   <= '0;
            r_rs    <= '0;
            r_rt    <= '0;
            r_rd    <= '0;
            r_rsd   <= '0;
            r_rtd   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_valid <= w_valid_next;
            r_ex    <= w_ex_next;
            r_mem   <= w_mem_next;
            r_rs    <= w_rs_next;
            r_rt    <= w_rt_next;
            r_rd    <= w_rd_next;
            r_rsd   <= w_rsd_next;
            r_rtd   <= w_rtd_next;
        end
    end

    assign IDStall   = rst_n & ~Flush & (ExStall | w_hazard | (r_state == ST_HAZARD));
    assign OutValid  = r_valid;
    assign OutEX     = r_ex;
    assign OutMEM    = r_mem;
    assign OutRs     = r_rs;
    assign OutRt     = r_rt;
    assign OutRd     = r_rd;
    assign OutRsData = r_rsd;
    assign OutRtData = r_rtd;

endmodule

`default_nettype wire
